// File: rtl/inertial_interface_if.sv
// Bus between the inertial sequencer, its SPI master and the integrator.
// Handshake: wrt is a one-cycle request carrying cmd; the SPI side answers with a one-cycle done (plus rd_data), and no new wrt is issued before that done.
interface inertial_interface_if;
    logic        INT;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic        vld;

    modport master (
        input  INT, done, rd_data,
        output wrt, cmd, ptch_rt, AZ, vld
    );

    modport slave (
        output INT, done, rd_data,
        input  wrt, cmd, ptch_rt, AZ, vld
    );
endinterface

// File: rtl/inertial_interface.sv
// Sequencer: power-up delay, sensor configuration over SPI, then a four-register
// read burst per data-ready interrupt, publishing ptch_rt/AZ as a coherent pair.
module inertial_interface #(
    parameter int TMR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inertial_interface_if.master bus,
    output logic [3:0]           dbg_state
);

    typedef enum logic [3:0] {
        PWRUP = 4'd0,
        CFG0  = 4'd1,
        CFG1  = 4'd2,
        CFG2  = 4'd3,
        CFG3  = 4'd4,
        IDLE  = 4'd5,
        RD_PL = 4'd6,
        RD_PH = 4'd7,
        RD_AL = 4'd8,
        RD_AH = 4'd9
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             int_ff1_q, int_ff1_d;
    logic             int_s_q, int_s_d;
    logic             wrt_q, wrt_d;
    logic [15:0]      cmd_q, cmd_d;
    logic [7:0]       pl_q, pl_d;
    logic [7:0]       ph_q, ph_d;
    logic [7:0]       al_q, al_d;
    logic [15:0]      ptch_q, ptch_d;
    logic [15:0]      az_q, az_d;
    logic             vld_q, vld_d;
    logic             unused_rd_hi;

    assign unused_rd_hi = ^bus.rd_data[15:8];

    function automatic logic [15:0] cmd_for(input state_t s);
        case (s)
            CFG0:    cmd_for = 16'h0D02;
            CFG1:    cmd_for = 16'h1053;
            CFG2:    cmd_for = 16'h1150;
            CFG3:    cmd_for = 16'h1460;
            RD_PL:   cmd_for = 16'hA200;
            RD_PH:   cmd_for = 16'hA300;
            RD_AL:   cmd_for = 16'hAC00;
            RD_AH:   cmd_for = 16'hAD00;
            default: cmd_for = 16'h0000;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        int_ff1_d = bus.INT;
        int_s_d   = int_ff1_q;
        wrt_d     = 1'b0;
        cmd_d     = cmd_q;
        pl_d      = pl_q;
        ph_d      = ph_q;
        al_d      = al_q;
        ptch_d    = ptch_q;
        az_d      = az_q;
        vld_d     = 1'b0;

        case (state_q)
            PWRUP: begin
                cnt_d = cnt_q + TMR_W'(1);
                if (&cnt_q) state_d = CFG0;
            end
            IDLE: begin
                if (int_s_q) state_d = RD_PL;
            end
            default: begin
                // A done arriving in the wrt cycle belongs to nothing we issued.
                if (bus.done && !wrt_q) begin
                    case (state_q)
                        CFG0:  state_d = CFG1;
                        CFG1:  state_d = CFG2;
                        CFG2:  state_d = CFG3;
                        CFG3:  state_d = IDLE;
                        RD_PL: begin
                            pl_d    = bus.rd_data[7:0];
                            state_d = RD_PH;
                        end
                        RD_PH: begin
                            ph_d    = bus.rd_data[7:0];
                            state_d = RD_AL;
                        end
                        RD_AL: begin
                            al_d    = bus.rd_data[7:0];
                            state_d = RD_AH;
                        end
                        RD_AH: begin
                            ptch_d  = {ph_q, pl_q};
                            az_d    = {bus.rd_data[7:0], al_q};
                            vld_d   = 1'b1;
                            state_d = IDLE;
                        end
                        default: state_d = state_q;
                    endcase
                end
            end
        endcase

        // Every entry into a transaction state launches exactly one command.
        if ((state_d != state_q) && (state_d != IDLE) && (state_d != PWRUP)) begin
            wrt_d = 1'b1;
            cmd_d = cmd_for(state_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= PWRUP;
            cnt_q     <= '0;
            int_ff1_q <= 1'b0;
            int_s_q   <= 1'b0;
            wrt_q     <= 1'b0;
            cmd_q     <= 16'h0000;
            pl_q      <= 8'h00;
            ph_q      <= 8'h00;
            al_q      <= 8'h00;
            ptch_q    <= 16'h0000;
            az_q      <= 16'h0000;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            int_ff1_q <= int_ff1_d;
            int_s_q   <= int_s_d;
            wrt_q     <= wrt_d;
            cmd_q     <= cmd_d;
            pl_q      <= pl_d;
            ph_q      <= ph_d;
            al_q      <= al_d;
            ptch_q    <= ptch_d;
            az_q      <= az_d;
            vld_q     <= vld_d;
        end
    end

    assign bus.wrt     = wrt_q;
    assign bus.cmd     = cmd_q;
    assign bus.ptch_rt = ptch_q;
    assign bus.AZ      = az_q;
    assign bus.vld     = vld_q;
    assign dbg_state   = state_q;

endmodule
